picomem_arbiter_2_1: RTL and testbench

- Two-master, one-slave arbiter for the PicoMem bus (valid/ready/addr/wdata/wstrb/rdata).
- Lets a second bus master (DMA or debug loader) share the SoC PicoMem fabric with the picorv32 core.
- Sits between the masters and the 1-to-4 address mux.
- Round-robin grant, held for one whole transaction, with a slave-response watchdog that completes hung accesses with an error word.

---
 rtl/picomem_pkg.sv | 18 +
 rtl/picomem_watchdog.sv | 30 +++
 rtl/picomem_arbiter_2_1.sv | 140 ++++++++++++++
 tb/tb_picomem_arbiter_2_1.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picomem_pkg.sv
// Shared PicoMem bus widths, arbiter state encoding and defaults.
package picomem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
  localparam int unsigned DRAIN_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/picomem_watchdog.sv
// Saturating cycle counter that flags the LIMIT-th enabled cycle after load.
module picomem_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] TOP = CW'(LIMIT);
  localparam logic [CW-1:0] LAST = CW'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (LIMIT == 0 || load) begin
      cnt <= '0;
    end else if (enable && cnt != TOP) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (LIMIT != 0) && enable && !load && (cnt == LAST);

endmodule

// File: rtl/picomem_arbiter_2_1.sv
// Two-master round-robin PicoMem arbiter with slave-response watchdog
// and a drain phase that swallows late slave completions.
module picomem_arbiter_2_1
  import picomem_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEF,
  parameter bit                INIT_PRIO      = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              timeout_err,
  output logic              timeout_master
);

  arb_state_t state, state_n;
  logic prio, prio_n;
  logic tm_n, terr_set;
  logic g, g_valid, done;
  logic [DATA_W-1:0] rd;
  logic wd_load, wd_exp;
  logic dr_load, dr_exp;

  assign g = (state == GNT1);

  picomem_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .load   (wd_load),
    .enable (state == GNT0 || state == GNT1),
    .expire (wd_exp)
  );

  picomem_watchdog #(
    .LIMIT (DRAIN_CYCLES)
  ) u_drain (
    .clk    (clk),
    .reset  (reset),
    .load   (dr_load),
    .enable (state == DRAIN),
    .expire (dr_exp)
  );

  always_comb begin
    state_n  = state;
    prio_n   = prio;
    tm_n     = timeout_master;
    terr_set = 1'b0;
    wd_load  = 1'b0;
    dr_load  = 1'b0;
    done     = 1'b0;
    rd       = '0;
    g_valid  = 1'b0;
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    unique case (state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_n = prio ? GNT1 : GNT0;
          wd_load = 1'b1;
        end else if (m0_valid) begin
          state_n = GNT0;
          wd_load = 1'b1;
        end else if (m1_valid) begin
          state_n = GNT1;
          wd_load = 1'b1;
        end
      end
      GNT0, GNT1: begin
        g_valid = g ? m1_valid : m0_valid;
        s_valid = g_valid;
        s_addr  = g ? m1_addr : m0_addr;
        s_wdata = g ? m1_wdata : m0_wdata;
        s_wstrb = g ? m1_wstrb : m0_wstrb;
        if (!g_valid) begin
          state_n = IDLE;
        end else if (s_ready || wd_exp) begin
          // s_ready beats a coincident expiry
          done   = 1'b1;
          rd     = s_ready ? s_rdata : ERR_RDATA;
          prio_n = ~g;
          if (s_ready) begin
            state_n = IDLE;
          end else begin
            state_n  = DRAIN;
            dr_load  = 1'b1;
            terr_set = 1'b1;
            tm_n     = g;
          end
        end
      end
      DRAIN: begin
        if (s_ready || dr_exp) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign m0_ready = done && !g;
  assign m1_ready = done && g;
  assign m0_rdata = m0_ready ? rd : '0;
  assign m1_rdata = m1_ready ? rd : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      prio           <= INIT_PRIO;
      timeout_err    <= 1'b0;
      timeout_master <= 1'b0;
    end else begin
      state          <= state_n;
      prio           <= prio_n;
      timeout_err    <= timeout_err | terr_set;
      timeout_master <= tm_n;
    end
  end

endmodule

// File: tb/tb_picomem_arbiter_2_1.sv
// Randomized and directed bench for picomem_arbiter_2_1 against a
// transaction-level reference model.
module tb_picomem_arbiter_2_1;

  localparam int T = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset;
  logic mv[2];
  logic [31:0] ma[2];
  logic [31:0] mw[2];
  logic [3:0] ms[2];
  logic m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0] s_wstrb;
  logic timeout_err, timeout_master;

  always #5 clk = ~clk;

  picomem_arbiter_2_1 #(
    .TIMEOUT_CYCLES (T),
    .ERR_RDATA      (ERR),
    .INIT_PRIO      (1'b0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_valid       (mv[0]),
    .m0_ready       (m0_ready),
    .m0_addr        (ma[0]),
    .m0_wdata       (mw[0]),
    .m0_wstrb       (ms[0]),
    .m0_rdata       (m0_rdata),
    .m1_valid       (mv[1]),
    .m1_ready       (m1_ready),
    .m1_addr        (ma[1]),
    .m1_wdata       (mw[1]),
    .m1_wstrb       (ms[1]),
    .m1_rdata       (m1_rdata),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_addr         (s_addr),
    .s_wdata        (s_wdata),
    .s_wstrb        (s_wstrb),
    .s_rdata        (s_rdata),
    .timeout_err    (timeout_err),
    .timeout_master (timeout_master)
  );

  int total = 0;
  int bad = 0;

  task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // model: phase 0 idle, 1 owner serving, 2 draining
  int md, mo, mel, mdr, mprio, merr, mtm;
  int n_md, n_mo, n_mel, n_mdr, n_prio, n_err, n_tm;
  int waitc[2];
  logic e_sv;
  logic [31:0] e_sa, e_sw;
  logic [3:0] e_ss;
  logic e_rdy[2];
  logic [31:0] e_rd[2];

  task automatic model_reset();
    md = 0; mo = 0; mel = 0; mdr = 0;
    mprio = 0; merr = 0; mtm = 0;
    waitc[0] = 0; waitc[1] = 0;
    e_rdy[0] = 1'b0; e_rdy[1] = 1'b0;
  endtask

  task automatic settle_check();
    #1;
    e_sv = 1'b0; e_sa = '0; e_sw = '0; e_ss = '0;
    e_rdy[0] = 1'b0; e_rdy[1] = 1'b0;
    e_rd[0] = '0; e_rd[1] = '0;
    n_md = md; n_mo = mo; n_mel = mel; n_mdr = mdr;
    n_prio = mprio; n_err = merr; n_tm = mtm;
    if (md == 0) begin
      if (mv[0] && mv[1]) begin
        n_md = 1; n_mo = mprio; n_mel = 0;
      end else if (mv[0] || mv[1]) begin
        n_md = 1; n_mo = mv[1] ? 1 : 0; n_mel = 0;
      end
    end else if (md == 1) begin
      e_sv = mv[mo]; e_sa = ma[mo]; e_sw = mw[mo]; e_ss = ms[mo];
      if (!mv[mo]) begin
        n_md = 0;
      end else if (s_ready) begin
        e_rdy[mo] = 1'b1; e_rd[mo] = s_rdata;
        n_md = 0; n_prio = 1 - mo;
      end else if (mel == T - 1) begin
        e_rdy[mo] = 1'b1; e_rd[mo] = ERR;
        n_md = 2; n_mdr = 0; n_err = 1; n_tm = mo; n_prio = 1 - mo;
      end else begin
        n_mel = mel + 1;
      end
    end else begin
      if (s_ready || mdr == 15) n_md = 0;
      else n_mdr = mdr + 1;
    end
    chk1("s_valid", s_valid, e_sv);
    chk32("s_addr", s_addr, e_sa);
    chk32("s_wdata", s_wdata, e_sw);
    chk32("s_wstrb", {28'd0, s_wstrb}, {28'd0, e_ss});
    chk1("m0_ready", m0_ready, e_rdy[0]);
    chk1("m1_ready", m1_ready, e_rdy[1]);
    chk32("m0_rdata", m0_rdata, e_rd[0]);
    chk32("m1_rdata", m1_rdata, e_rd[1]);
    chk1("timeout_err", timeout_err, merr != 0);
    chk1("timeout_master", timeout_master, mtm != 0);
    for (int i = 0; i < 2; i++)
      if (!mv[i]) waitc[i] = 0;
    for (int j = 0; j < 2; j++) begin
      if (e_rdy[j]) begin
        if (mv[1-j]) begin
          waitc[1-j]++;
          chk1("starvation", waitc[1-j] <= 1, 1'b1);
        end
        waitc[j] = 0;
      end
    end
  endtask

  task automatic advance();
    md = n_md; mo = n_mo; mel = n_mel; mdr = n_mdr;
    mprio = n_prio; merr = n_err; mtm = n_tm;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk1("rst_s_valid", s_valid, 1'b0);
    chk32("rst_s_addr", s_addr, 32'h0);
    chk1("rst_m0_ready", m0_ready, 1'b0);
    chk1("rst_m1_ready", m1_ready, 1'b0);
    chk1("rst_terr", timeout_err, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic new_req(int i);
    mv[i] = 1'b1;
    ma[i] = $urandom;
    mw[i] = $urandom;
    ms[i] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    logic done_prev[2];
    int pct;
    reset = 1'b1;
    s_ready = 1'b0;
    s_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; ma[i] = '0; mw[i] = '0; ms[i] = '0;
    end
    model_reset();
    #2;
    chk1("init_s_valid", s_valid, 1'b0);
    chk1("init_terr", timeout_err, 1'b0);
    chk1("init_tm", timeout_master, 1'b0);
    chk32("init_m0_rdata", m0_rdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single master read, slave answers on fourth grant cycle
    mv[0] = 1'b1; ma[0] = 32'h0000_0010; mw[0] = '0; ms[0] = 4'h0;
    settle_check();
    chk1("t1_idle_sv", s_valid, 1'b0);
    advance();
    for (int i = 0; i < 4; i++) begin
      s_ready = (i == 3);
      s_rdata = (i == 3) ? 32'h1234_5678 : 32'h0;
      settle_check();
      chk1("t1_sv", s_valid, 1'b1);
      chk32("t1_addr", s_addr, 32'h0000_0010);
      chk1("t1_rdy0", m0_ready, i == 3);
      chk32("t1_rd0", m0_rdata, (i == 3) ? 32'h1234_5678 : 32'h0);
      chk1("t1_rdy1", m1_ready, 1'b0);
      advance();
    end
    mv[0] = 1'b0; s_ready = 1'b0;
    settle_check();
    chk1("t1_after", m0_ready, 1'b0);
    advance();

    // simultaneous writes after reset
    do_reset();
    mv[0] = 1'b1; ma[0] = 32'h100; mw[0] = 32'h11; ms[0] = 4'hF;
    mv[1] = 1'b1; ma[1] = 32'h200; mw[1] = 32'h22; ms[1] = 4'hF;
    settle_check();
    advance();
    s_ready = 1'b1; s_rdata = 32'h0;
    settle_check();
    chk32("t2_first_addr", s_addr, 32'h100);
    chk1("t2_first_rdy0", m0_ready, 1'b1);
    chk1("t2_first_rdy1", m1_ready, 1'b0);
    advance();
    ma[0] = 32'h104; s_ready = 1'b0;
    settle_check();
    advance();
    s_ready = 1'b1;
    settle_check();
    chk32("t2_second_addr", s_addr, 32'h200);
    chk1("t2_second_rdy1", m1_ready, 1'b1);
    advance();

    // continuous contention alternates owners
    for (int k = 0; k < 8; k++) begin
      s_ready = 1'b0;
      settle_check();
      advance();
      s_ready = 1'b1; s_rdata = 32'(k);
      settle_check();
      chk1("t3_rdy0", m0_ready, (k % 2) == 0);
      chk1("t3_rdy1", m1_ready, (k % 2) == 1);
      advance();
    end
    mv[0] = 1'b0; mv[1] = 1'b0; s_ready = 1'b0;
    settle_check();
    advance();

    // slave hang on master 1
    do_reset();
    mv[1] = 1'b1; ma[1] = 32'h300; ms[1] = 4'h0;
    settle_check();
    advance();
    for (int i = 0; i < T; i++) begin
      settle_check();
      chk1("t4_rdy1", m1_ready, i == T - 1);
      chk32("t4_rd1", m1_rdata, (i == T - 1) ? ERR : 32'h0);
      advance();
    end
    mv[1] = 1'b0;
    settle_check();
    chk1("t4_terr", timeout_err, 1'b1);
    chk1("t4_tm", timeout_master, 1'b1);
    advance();
    s_ready = 1'b1;
    settle_check();
    chk1("t4_late0", m0_ready, 1'b0);
    chk1("t4_late1", m1_ready, 1'b0);
    advance();
    s_ready = 1'b0;
    settle_check();
    advance();

    // s_ready on the expiry cycle
    do_reset();
    mv[0] = 1'b1; ma[0] = 32'h400;
    settle_check();
    advance();
    for (int i = 0; i < T; i++) begin
      s_ready = (i == T - 1);
      s_rdata = 32'hA5A5_5A5A;
      settle_check();
      chk1("t5_rdy0", m0_ready, i == T - 1);
      advance();
    end
    mv[0] = 1'b0; s_ready = 1'b0;
    settle_check();
    chk1("t5_terr", timeout_err, 1'b0);
    advance();

    // valid dropped mid-grant
    mv[0] = 1'b1;
    settle_check();
    advance();
    for (int i = 0; i < 2; i++) begin
      settle_check();
      advance();
    end
    mv[0] = 1'b0;
    settle_check();
    chk1("t6_no_rdy", m0_ready, 1'b0);
    advance();
    settle_check();
    chk1("t6_idle", s_valid, 1'b0);
    advance();

    // reset during an active grant
    mv[1] = 1'b1; ma[1] = 32'h500;
    settle_check();
    advance();
    settle_check();
    chk1("t7_busy", s_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk1("t7_rst_sv", s_valid, 1'b0);
    chk32("t7_rst_addr", s_addr, 32'h0);
    chk1("t7_rst_rdy1", m1_ready, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mv[0] = 1'b1; ma[0] = 32'h600;
    settle_check();
    advance();
    s_ready = 1'b1;
    settle_check();
    chk32("t7_first_addr", s_addr, 32'h600);
    advance();
    mv[0] = 1'b0; mv[1] = 1'b0; s_ready = 1'b0;
    settle_check();
    advance();

    // randomized traffic
    done_prev[0] = 1'b0; done_prev[1] = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      pct = ((c / 500) % 3 == 2) ? 3 : 35;
      for (int i = 0; i < 2; i++) begin
        if (!mv[i]) begin
          if ($urandom_range(0, 3) == 0) new_req(i);
        end else if (done_prev[i]) begin
          if ($urandom_range(0, 1) == 0) new_req(i);
          else mv[i] = 1'b0;
        end else if ($urandom_range(0, 63) == 0) begin
          mv[i] = 1'b0;
        end
      end
      s_ready = ($urandom_range(0, 99) < pct);
      s_rdata = $urandom;
      settle_check();
      done_prev[0] = e_rdy[0];
      done_prev[1] = e_rdy[1];
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
